// File: rtl/otter_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// otter_io_pkg
// Shared definitions for the OTTER IOBUS UART transmitter: the transmit FSM
// state type, register offsets relative to the block base address, and the
// bit positions of the fields in the STATUS register.
// ---------------------------------------------------------------------------
package otter_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [31:0] UART_DATA_OFS = 32'd0;
  localparam logic [31:0] UART_STAT_OFS = 32'd4;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVR_BIT   = 3;
  localparam int STAT_CNT_LSB   = 8;

endpackage

// File: rtl/otter_uart_tx_if.sv
// ---------------------------------------------------------------------------
// otter_iobus_if
// CPU-side IOBUS connection for a memory-mapped responder.
//   IOBUS_ADDR : byte address from the CPU
//   IOBUS_OUT  : CPU store data
//   IOBUS_WR   : store strobe, sampled on the rising clock edge
//   IOBUS_IN   : read data returned by the responder (combinational)
// The master modport is the CPU side, the slave modport the peripheral side.
// ---------------------------------------------------------------------------
interface otter_iobus_if;

  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  IOBUS_IN
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output IOBUS_IN
  );

endinterface

// File: rtl/otter_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// otter_sync_fifo
// Single-clock first-word-fall-through FIFO. dout always shows the oldest
// entry; pop simply advances past it.
//   CLK, RESET_N : clock and asynchronous active-low reset
//   push, din    : write request and data (ignored when full)
//   pop          : read request (ignored when empty)
//   dout         : head entry
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by overflowing.
// ---------------------------------------------------------------------------
module otter_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Simultaneous push and pop moves both pointers and leaves count alone.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/otter_uart_tx.sv
// ---------------------------------------------------------------------------
// otter_uart_tx
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS.
//   CLK, RESET_N : clock and asynchronous active-low reset
//   iobus        : IOBUS slave (DATA at BASE_ADDR+0, STATUS at BASE_ADDR+4)
//   TX           : serial output, idle high, registered
//   IRQ          : one-cycle pulse when the last queued frame finishes
// STATUS: [0] full, [1] empty, [2] busy, [3] overrun (sticky, cleared by
// any write to STATUS), [15:8] FIFO count.
// ---------------------------------------------------------------------------
module otter_uart_tx
  import otter_io_pkg::*;
#(
  parameter int          CLK_RATE   = 50,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0040
) (
  input  logic          CLK,
  input  logic          RESET_N,
  otter_iobus_if.slave  iobus,
  output logic          TX,
  output logic          IRQ
);

  localparam int DIV    = (CLK_RATE * 1_000_000) / BAUD;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_AW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic              data_sel;
  logic              stat_sel;
  logic              data_wr;
  logic              stat_wr;
  logic              overrun;
  logic [31:0]       status_word;
  logic              unused_bits;

  logic              fifo_push;
  logic              fifo_pop;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_AW-1:0] fifo_count;

  tx_state_t         state;
  tx_state_t         state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [2:0]        bitidx;
  logic [2:0]        bitidx_next;
  logic [7:0]        shift;
  logic [7:0]        shift_next;
  logic              load;
  logic              bit_end;
  logic              tx_next;
  logic              irq_next;

  // Only the low byte of a DATA store is transmitted.
  assign unused_bits = ^iobus.IOBUS_OUT[31:8];

  assign data_sel  = (iobus.IOBUS_ADDR == BASE_ADDR + UART_DATA_OFS);
  assign stat_sel  = (iobus.IOBUS_ADDR == BASE_ADDR + UART_STAT_OFS);
  assign data_wr   = iobus.IOBUS_WR && data_sel;
  assign stat_wr   = iobus.IOBUS_WR && stat_sel;
  assign fifo_push = data_wr && !fifo_full;

  otter_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (iobus.IOBUS_OUT[7:0]),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A store to a full FIFO is dropped and remembered until software
  // acknowledges it by writing STATUS.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      overrun <= 1'b0;
    end else if (stat_wr) begin
      overrun <= 1'b0;
    end else if (data_wr && fifo_full) begin
      overrun <= 1'b1;
    end
  end

  // STATUS assembly; DATA and unmapped addresses read as zero.
  always_comb begin
    status_word                         = '0;
    status_word[STAT_FULL_BIT]          = fifo_full;
    status_word[STAT_EMPTY_BIT]         = fifo_empty;
    status_word[STAT_BUSY_BIT]          = (state != IDLE);
    status_word[STAT_OVR_BIT]           = overrun;
    status_word[STAT_CNT_LSB +: 8]      = 8'(fifo_count);
  end

  assign iobus.IOBUS_IN = stat_sel ? status_word : 32'h0;

  assign bit_end = (cnt == CNT_MAX);

  // Next-state logic. STOP pops the next byte directly so consecutive
  // frames are seamless; the done interrupt fires only when the queue is dry.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    bitidx_next = bitidx;
    fifo_pop    = 1'b0;
    load        = 1'b0;
    irq_next    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          load       = 1'b1;
          cnt_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_next    = '0;
          bitidx_next = 3'd0;
          state_next  = DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (bitidx == 3'd7) begin
            bitidx_next = 3'd0;
            state_next  = STOP;
          end else begin
            bitidx_next = bitidx + 3'd1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            load       = 1'b1;
            state_next = START;
          end else begin
            irq_next   = 1'b1;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // TX is derived from the upcoming state so the registered line changes
  // exactly on bit boundaries.
  always_comb begin
    shift_next = load ? fifo_dout : shift;
    tx_next    = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bitidx_next];
      default: tx_next = 1'b1;
    endcase
  end

  // State register; reset forces the line idle without a clock edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      cnt    <= '0;
      bitidx <= 3'd0;
      shift  <= 8'h00;
      TX     <= 1'b1;
      IRQ    <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      bitidx <= bitidx_next;
      shift  <= shift_next;
      TX     <= tx_next;
      IRQ    <= irq_next;
    end
  end

endmodule

// File: tb/tb_otter_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_otter_uart_tx
// Directed self-checking bench for otter_uart_tx with CLK_RATE=1 MHz and
// BAUD=250000, giving four clock cycles per bit and forty per frame.
// Cycle k below means the interval just after the k-th rising edge
// following the edge that sampled the first DATA write.
// ---------------------------------------------------------------------------
module tb_otter_uart_tx;

  localparam logic [31:0] BASE = 32'h1100_0040;
  localparam logic [31:0] STAT = 32'h1100_0044;

  logic CLK = 1'b0;
  logic RESET_N;
  logic TX;
  logic IRQ;

  int tests_run    = 0;
  int tests_failed = 0;

  otter_iobus_if bus ();

  otter_uart_tx #(
    .CLK_RATE   (1),
    .BAUD       (250000),
    .FIFO_DEPTH (16),
    .BASE_ADDR  (BASE)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .iobus   (bus),
    .TX      (TX),
    .IRQ     (IRQ)
  );

  always #5 CLK = ~CLK;

  // Advance one edge and settle 1 ns past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.IOBUS_ADDR = addr;
    bus.IOBUS_OUT  = data;
    bus.IOBUS_WR   = 1'b1;
    tick();
    bus.IOBUS_WR   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.IOBUS_WR   = 1'b0;
    bus.IOBUS_ADDR = addr;
    #1;
    data = bus.IOBUS_IN;
  endtask

  task automatic apply_reset();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
  endtask

  // Expected line level at position j (0..39) of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j < 4)       return 1'b0;
    else if (j < 36) return b[(j - 4) / 4];
    else             return 1'b1;
  endfunction

  task automatic test_reset();
    logic [31:0] rd;
    RESET_N = 1'b0;
    tick();
    tick();
    tests_run++;
    if (TX !== 1'b1 || IRQ !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: TX=%b IRQ=%b expected TX=1 IRQ=0", TX, IRQ);
    end
    RESET_N = 1'b1;
    tick();
    tests_run++;
    if (TX !== 1'b1 || IRQ !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: TX=%b IRQ=%b expected TX=1 IRQ=0", TX, IRQ);
    end
    bus_read(STAT, rd);
    tests_run++;
    if (rd !== 32'h0000_0002) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got %h expected 00000002", rd);
    end
    bus_read(BASE, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL data_read: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] rd;
    logic        exp_tx;
    logic        exp_irq;
    apply_reset();
    bus_write(BASE, 32'hFFFF_FFA5);
    bus_read(STAT, rd);
    tests_run++;
    if (rd !== 32'h0000_0100) begin
      tests_failed++;
      $display("[TB] FAIL queued_status: got %h expected 00000100", rd);
    end
    tests_run++;
    if (TX !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_start_tx: TX=%b expected 1", TX);
    end
    for (int k = 1; k <= 42; k++) begin
      tick();
      exp_tx  = (k <= 40) ? frame_bit(8'hA5, k - 1) : 1'b1;
      exp_irq = (k == 41);
      tests_run++;
      if (TX !== exp_tx) begin
        tests_failed++;
        $display("[TB] FAIL frame_tx cycle %0d: TX=%b expected %b", k, TX, exp_tx);
      end
      tests_run++;
      if (IRQ !== exp_irq) begin
        tests_failed++;
        $display("[TB] FAIL frame_irq cycle %0d: IRQ=%b expected %b", k, IRQ, exp_irq);
      end
      if (k == 1) begin
        bus_read(STAT, rd);
        tests_run++;
        if (rd !== 32'h0000_0006) begin
          tests_failed++;
          $display("[TB] FAIL busy_status: got %h expected 00000006", rd);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    apply_reset();
    bus_write(BASE, 32'h55);
    tick();
    for (int i = 0; i < 16; i++) begin
      bus_write(BASE, 32'h10 + 32'(i));
    end
    bus_read(STAT, rd);
    tests_run++;
    if (rd !== 32'h0000_1005) begin
      tests_failed++;
      $display("[TB] FAIL fifo_full: got %h expected 00001005", rd);
    end
    bus_write(BASE, 32'hEE);
    bus_read(STAT, rd);
    tests_run++;
    if (rd !== 32'h0000_100D) begin
      tests_failed++;
      $display("[TB] FAIL overrun_set: got %h expected 0000100D", rd);
    end
    bus_write(STAT, 32'h0);
    bus_read(STAT, rd);
    tests_run++;
    if (rd !== 32'h0000_1005) begin
      tests_failed++;
      $display("[TB] FAIL overrun_clear: got %h expected 00001005", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_tx;
    logic prev_tx;
    int   falls;
    int   first_fall;
    int   second_fall;
    int   irq_count;
    int   irq_cycle;
    apply_reset();
    bus_write(BASE, 32'h00);
    bus_write(BASE, 32'hFF);
    prev_tx     = 1'b1;
    falls       = 0;
    first_fall  = -1;
    second_fall = -1;
    irq_count   = 0;
    irq_cycle   = -1;
    for (int k = 1; k <= 90; k++) begin
      if (k > 1) tick();
      if (k <= 40)      exp_tx = frame_bit(8'h00, k - 1);
      else if (k <= 80) exp_tx = frame_bit(8'hFF, k - 41);
      else              exp_tx = 1'b1;
      tests_run++;
      if (TX !== exp_tx) begin
        tests_failed++;
        $display("[TB] FAIL b2b_tx cycle %0d: TX=%b expected %b", k, TX, exp_tx);
      end
      if (prev_tx === 1'b1 && TX === 1'b0) begin
        falls++;
        if (falls == 1) first_fall = k;
        if (falls == 2) second_fall = k;
      end
      prev_tx = TX;
      if (IRQ === 1'b1) begin
        irq_count++;
        irq_cycle = k;
      end
    end
    tests_run++;
    if (falls != 2 || second_fall - first_fall != 40) begin
      tests_failed++;
      $display("[TB] FAIL b2b_gap: falls=%0d spacing=%0d expected falls=2 spacing=40",
               falls, second_fall - first_fall);
    end
    tests_run++;
    if (irq_count != 1 || irq_cycle != 81) begin
      tests_failed++;
      $display("[TB] FAIL b2b_irq: pulses=%0d at cycle %0d expected 1 pulse at cycle 81",
               irq_count, irq_cycle);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    int          irq_count;
    int          low_count;
    apply_reset();
    bus_write(BASE, 32'h00);
    bus_write(BASE, 32'h11);
    bus_write(BASE, 32'h22);
    bus_write(BASE, 32'h33);
    bus_read(STAT, rd);
    tests_run++;
    if (rd !== 32'h0000_0304) begin
      tests_failed++;
      $display("[TB] FAIL queued3_status: got %h expected 00000304", rd);
    end
    repeat (7) tick();
    tests_run++;
    if (TX !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_data_tx: TX=%b expected 0", TX);
    end
    RESET_N = 1'b0;
    #1;
    tests_run++;
    if (TX !== 1'b1 || IRQ !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: TX=%b IRQ=%b expected TX=1 IRQ=0", TX, IRQ);
    end
    #2;
    RESET_N = 1'b1;
    bus_read(STAT, rd);
    tests_run++;
    if (rd !== 32'h0000_0002) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_status: got %h expected 00000002", rd);
    end
    irq_count = 0;
    low_count = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (IRQ !== 1'b0) irq_count++;
      if (TX !== 1'b1) low_count++;
    end
    tests_run++;
    if (irq_count != 0 || low_count != 0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_quiet: irq_cycles=%0d tx_low_cycles=%0d expected 0 and 0",
               irq_count, low_count);
    end
  endtask

  task automatic test_bad_address();
    logic [31:0] rd;
    apply_reset();
    bus_read(BASE + 32'd8, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL read_base_plus8: got %h expected 00000000", rd);
    end
    bus_read(BASE - 32'd4, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL read_base_minus4: got %h expected 00000000", rd);
    end
    bus_write(BASE + 32'd8, 32'hFFFF_FFFF);
    bus_write(BASE - 32'd4, 32'hFFFF_FFFF);
    tick();
    bus_read(STAT, rd);
    tests_run++;
    if (rd !== 32'h0000_0002) begin
      tests_failed++;
      $display("[TB] FAIL bad_write_status: got %h expected 00000002", rd);
    end
    tests_run++;
    if (TX !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bad_write_tx: TX=%b expected 1", TX);
    end
  endtask

  initial begin
    RESET_N        = 1'b0;
    bus.IOBUS_ADDR = 32'h0;
    bus.IOBUS_OUT  = 32'h0;
    bus.IOBUS_WR   = 1'b0;
    test_reset();
    test_single_frame();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_bad_address();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/otter_uart_tx.md
# otter_uart_tx

Memory-mapped UART transmitter that acts as a responder on the OTTER MCU's IOBUS. CPU stores to its data register push bytes into a transmit FIFO. A baud-rate state machine serializes each byte onto a TX pin as 8N1, LSB first. The block sits beside the CPU on the IOBUS and is the transmit-side counterpart to the serial receive path used by the programmer.

## Interface

**Parameters**
- `CLK_RATE`, default 50: clock frequency in MHz, integer.
- `BAUD`, default 115200: bit rate.
- `FIFO_DEPTH`, default 16: FIFO entries; must be a power of 2, at least 2.
- `BASE_ADDR`, default 32'h1100_0040: word-aligned register base address.

**Ports**
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `CLK`, in, 1: system clock; all state updates on its rising edge.
  - `RESET_N`, in, 1: asserting it clears all state immediately.
- `IOBUS_ADDR`, in, 32: CPU address.
- `IOBUS_OUT`, in, 32: CPU write data.
- `IOBUS_WR`, in, 1: write strobe, sampled at `CLK` rising edge.
- `IOBUS_IN`, out, 32: read data, combinational in `IOBUS_ADDR`.
- `TX`, out, 1: serial line, idle high, registered.
- `IRQ`, out, 1: one-cycle transmit-done pulse, registered.

## Operation

**Divisor**
- `DIV = (CLK_RATE*1_000_000)/BAUD`, integer truncation. Default value is 434.
- Bit counter width is `$clog2(DIV)`.

**Register map** (byte addresses)
- `BASE+0` DATA
  - Write pushes `IOBUS_OUT[7:0]`; upper bits are ignored.
  - Read returns 0.
- `BASE+4` STATUS, read-only except bit 3:
  - bit 0: full.
  - bit 1: empty.
  - bit 2: busy, meaning state is not IDLE.
  - bit 3: overrun, sticky. Any write to `BASE+4` clears it.
  - bits [15:8]: FIFO count, zero-extended.
  - All other bits read 0.
- Any other address: `IOBUS_IN` is 0 and writes are ignored.

**FIFO**
- Push on a DATA write when not full.
- A DATA write while full drops the byte and sets overrun.
- Push and pop in the same cycle: both take effect and the count is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.

**FSM** (states IDLE, START, DATA, STOP)
- Common behaviour:
  - A cycle counter `cnt` counts 0..DIV-1 in each bit period.
  - `bitidx` runs 0..7.
- IDLE:
  - `TX` is 1.
  - If the FIFO is non-empty: pop into the shift register, clear `cnt`, go to START.
- START:
  - `TX` is 0.
  - When `cnt` reaches DIV-1: go to DATA with `bitidx` = 0.
- DATA:
  - `TX` is `shift[bitidx]`.
  - When `cnt` reaches DIV-1: increment `bitidx`.
  - After bit 7 completes: go to STOP.
- STOP:
  - `TX` is 1.
  - When `cnt` reaches DIV-1, and the FIFO is non-empty: pop, then go directly to START with no extra idle bit.
  - When `cnt` reaches DIV-1, and the FIFO is empty: go to IDLE and pulse `IRQ` for one cycle.
- `TX` is registered from the next-state/next-bit value, so the line changes exactly at bit boundaries.

**Reset** (`RESET_N` low, asynchronous)
- Outputs:
  - `TX` = 1.
  - `IRQ` = 0.
- Internal state:
  - State = IDLE.
  - FIFO count and pointers = 0.
  - Overrun = 0.
  - `cnt` and `bitidx` = 0.
- Reset mid-frame aborts the frame and discards the FIFO contents. `TX` returns high without waiting for a clock edge.

## Timing

- A DATA write sampled at edge N leaves count = 1 after N, if the FIFO was empty.
- IDLE pops at edge N+1, and `TX` falls after edge N+1.
- Each bit lasts exactly DIV cycles. A frame lasts 10·DIV cycles.
- `IRQ` is high for the single cycle following the edge that ends the final stop bit.
- Back-to-back bytes have no gap: the start bit begins at the edge ending the previous stop bit.
- STATUS reflects register state after the most recent edge; it has zero wait states.

## Structure

- Shared package `otter_io_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - Register offsets `UART_DATA_OFS` = 0 and `UART_STAT_OFS` = 4.
  - STATUS bit-position constants.
- Sub-module `otter_sync_fifo`:
  - Parameters `WIDTH`, `DEPTH`.
  - Ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`.
  - `dout` shows the head entry: first-word fall-through.
- Top level contains the address decode, the overrun flag, the baud counter, and the FSM.

## Test plan

All scenarios use `CLK_RATE` = 1, `BAUD` = 250000, so DIV = 4.

1. Release reset → `TX` = 1, `IRQ` = 0, and STATUS reads 32'h0000_0002.
2. Write 32'hFFFF_FFA5 to DATA at edge N:
   - `TX` low on cycles N+1..N+4.
   - Then the bits 1,0,1,0,0,1,0,1 for 4 cycles each.
   - Then high for 4 cycles.
   - `IRQ` pulses once at cycle N+41.
3. Write 17 bytes in consecutive cycles while the first frame is in flight:
   - Count saturates at 16 with full = 1.
   - The 17th byte sets overrun.
   - A write to `BASE+4` clears overrun without changing count.
4. Write 8'h00 then 8'hFF back-to-back:
   - Second start bit begins exactly 40 cycles after the first.
   - `IRQ` pulses once, at the end of the second frame only.
5. Assert `RESET_N` low mid-DATA with 3 bytes queued:
   - `TX` goes high immediately.
   - STATUS reads 32'h0000_0002 after release.
   - No `IRQ`.
6. Read `BASE+8` and `BASE-4` → `IOBUS_IN` = 0; writes to those addresses leave STATUS unchanged.
